// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter. After reset it reads the reset vector and hands it to the
// PC. It then serves word/byte accesses from the execute and fetch units on a
// single memory bus. The execute unit has fixed priority over fetch.
//
// Handshake: a requester raises req and holds addr/data stable. The arbiter
// samples req at a clock edge while idle or responding. In the next cycle
// (address cycle) it pulses gnt. In the cycle after that it pulses rdy and
// presents read data. req still high at the edge that ends the rdy cycle is
// taken as a new request.
module mem_bus_arbiter #(
  parameter logic [15:0] VEC_ADDR = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_rdy,
  output logic [15:0] if_data,
  input  logic        ex_req,
  input  logic        ex_we,
  input  logic        ex_bw,
  input  logic [15:0] ex_addr,
  input  logic [15:0] ex_wdata,
  output logic        ex_gnt,
  output logic        ex_rdy,
  output logic [15:0] ex_rdata,
  output logic [15:0] MAB,
  output logic [15:0] MDB_out,
  input  logic [15:0] MDB_in,
  output logic        mem_re,
  output logic        mem_we,
  output logic        mem_bw,
  output logic        pc_load,
  output logic [15:0] pc_init,
  output logic        boot_done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_BOOT_A = 3'd1,
    S_BOOT_D = 3'd2,
    S_IDLE   = 3'd3,
    S_ACCESS = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t      state, state_next;
  logic        take_ex, take_if;
  logic        sel_ex, acc_we, acc_bw, acc_hi;
  logic [15:0] acc_addr, acc_wdata;

  assign dbg_state = state;

  // Arbitration: requests are only accepted while idle or in the response cycle.
  always_comb begin
    take_ex = 1'b0;
    take_if = 1'b0;
    if (state == S_IDLE || state == S_RESP) begin
      take_ex = ex_req;
      take_if = !ex_req && if_req;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_RESET;
    else      state <= state_next;
  end

  // Capture the winning request at the entry edge. The bus drives from these copies.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_ex    <= 1'b0;
      acc_we    <= 1'b0;
      acc_bw    <= 1'b0;
      acc_hi    <= 1'b0;
      acc_addr  <= 16'h0000;
      acc_wdata <= 16'h0000;
    end else if (take_ex) begin
      sel_ex    <= 1'b1;
      acc_we    <= ex_we;
      acc_bw    <= ex_bw;
      acc_hi    <= ex_addr[0];
      acc_addr  <= ex_bw ? ex_addr : {ex_addr[15:1], 1'b0};
      acc_wdata <= ex_bw ? {ex_wdata[7:0], ex_wdata[7:0]} : ex_wdata;
    end else if (take_if) begin
      sel_ex    <= 1'b0;
      acc_we    <= 1'b0;
      acc_bw    <= 1'b0;
      acc_hi    <= 1'b0;
      acc_addr  <= {if_addr[15:1], 1'b0};
      acc_wdata <= 16'h0000;
    end
  end

  // Next state and all outputs. Every output is quiet unless a state drives it.
  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    if_rdy     = 1'b0;
    if_data    = 16'h0000;
    ex_gnt     = 1'b0;
    ex_rdy     = 1'b0;
    ex_rdata   = 16'h0000;
    MAB        = 16'h0000;
    MDB_out    = 16'h0000;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_bw     = 1'b0;
    pc_load    = 1'b0;
    pc_init    = 16'h0000;
    boot_done  = 1'b0;
    case (state)
      S_RESET: state_next = S_BOOT_A;
      S_BOOT_A: begin
        MAB        = VEC_ADDR;
        mem_re     = 1'b1;
        state_next = S_BOOT_D;
      end
      S_BOOT_D: begin
        pc_load    = 1'b1;
        pc_init    = MDB_in;
        state_next = S_IDLE;
      end
      S_IDLE: begin
        boot_done  = 1'b1;
        state_next = (take_ex || take_if) ? S_ACCESS : S_IDLE;
      end
      S_ACCESS: begin
        boot_done  = 1'b1;
        ex_gnt     = sel_ex;
        if_gnt     = !sel_ex;
        MAB        = acc_addr;
        mem_re     = !acc_we;
        mem_we     = acc_we;
        mem_bw     = acc_bw;
        MDB_out    = acc_we ? acc_wdata : 16'h0000;
        state_next = S_RESP;
      end
      S_RESP: begin
        boot_done = 1'b1;
        if (sel_ex) begin
          ex_rdy = 1'b1;
          if (!acc_we)
            ex_rdata = acc_bw ? {8'h00, (acc_hi ? MDB_in[15:8] : MDB_in[7:0])} : MDB_in;
        end else begin
          if_rdy  = 1'b1;
          if_data = MDB_in;
        end
        state_next = (take_ex || take_if) ? S_ACCESS : S_IDLE;
      end
      default: state_next = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Inputs change and outputs are checked on
// the falling clock edge. A small memory model answers reads one cycle after
// the address cycle.
module tb_mem_bus_arbiter;

  logic        clk, rst;
  logic        if_req, if_gnt, if_rdy;
  logic [15:0] if_addr, if_data;
  logic        ex_req, ex_we, ex_bw, ex_gnt, ex_rdy;
  logic [15:0] ex_addr, ex_wdata, ex_rdata;
  logic [15:0] MAB, MDB_out, MDB_in, pc_init;
  logic        mem_re, mem_we, mem_bw, pc_load, boot_done;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [91:0] all_out;

  mem_bus_arbiter #(.VEC_ADDR(16'hFFFE)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdy(if_rdy), .if_data(if_data),
    .ex_req(ex_req), .ex_we(ex_we), .ex_bw(ex_bw), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_gnt(ex_gnt), .ex_rdy(ex_rdy), .ex_rdata(ex_rdata),
    .MAB(MAB), .MDB_out(MDB_out), .MDB_in(MDB_in),
    .mem_re(mem_re), .mem_we(mem_we), .mem_bw(mem_bw),
    .pc_load(pc_load), .pc_init(pc_init), .boot_done(boot_done), .dbg_state(dbg_state)
  );

  assign all_out = {dbg_state, if_gnt, if_rdy, if_data, ex_gnt, ex_rdy, ex_rdata, MAB, MDB_out,
                    mem_re, mem_we, mem_bw, pc_load, pc_init, boot_done};

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Memory model: word contents indexed by word address
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case ({a[15:1], 1'b0})
      16'hFFFE: mem_word = 16'hC000;
      16'hC000: mem_word = 16'h4031;
      16'hC002: mem_word = 16'h1111;
      16'h0200: mem_word = 16'hABCD;
      default:  mem_word = 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_re) MDB_in <= mem_word(MAB);
    else        MDB_in <= 16'h0000;
  end

  // Bus exclusivity monitor
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ((if_gnt && ex_gnt) || (if_rdy && ex_rdy) || (mem_re && mem_we)) begin
        failures++;
        $display("FAIL exclusive: gnt=%b%b rdy=%b%b re/we=%b%b required at most one of each pair",
                 if_gnt, ex_gnt, if_rdy, ex_rdy, mem_re, mem_we);
      end
    end
  end

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; ex_req = 0; ex_we = 0; ex_bw = 0; ex_addr = 0; ex_wdata = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk); @(negedge clk);
    checks++;
    if (all_out !== 92'd0) begin
      failures++; $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({MAB, mem_re, mem_we, mem_bw, pc_load, boot_done} !== {16'hFFFE, 5'b10000}) begin
      failures++; $display("FAIL boot_a: MAB=%h re=%b we=%b bw=%b load=%b done=%b required FFFE 1 0 0 0 0",
                           MAB, mem_re, mem_we, mem_bw, pc_load, boot_done);
    end
    @(negedge clk);
    checks++;
    if ({pc_load, pc_init, boot_done, mem_re} !== {1'b1, 16'hC000, 2'b00}) begin
      failures++; $display("FAIL boot_d: load=%b init=%h done=%b re=%b required 1 C000 0 0",
                           pc_load, pc_init, boot_done, mem_re);
    end
    @(negedge clk);
    checks++;
    if ({pc_load, pc_init, boot_done, dbg_state} !== {1'b0, 16'h0000, 1'b1, 3'd3}) begin
      failures++; $display("FAIL boot_idle: load=%b init=%h done=%b state=%0d required 0 0000 1 3",
                           pc_load, pc_init, boot_done, dbg_state);
    end
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 16'hC000;
    @(negedge clk);
    checks++;
    if ({if_gnt, ex_gnt, MAB, mem_re, mem_we, mem_bw} !== {2'b10, 16'hC000, 3'b100}) begin
      failures++; $display("FAIL fetch_gnt: gnt=%b%b MAB=%h re/we/bw=%b%b%b required 10 C000 100",
                           if_gnt, ex_gnt, MAB, mem_re, mem_we, mem_bw);
    end
    @(negedge clk);
    checks++;
    if ({if_rdy, ex_rdy, if_data, mem_re, MAB} !== {2'b10, 16'h4031, 1'b0, 16'h0000}) begin
      failures++; $display("FAIL fetch_rdy: rdy=%b%b data=%h re=%b MAB=%h required 10 4031 0 0000",
                           if_rdy, ex_rdy, if_data, mem_re, MAB);
    end
    if_req = 0;
    @(negedge clk);
    checks++;
    if ({if_rdy, if_gnt, if_data, dbg_state} !== {2'b00, 16'h0000, 3'd3}) begin
      failures++; $display("FAIL fetch_after: rdy=%b gnt=%b data=%h state=%0d required 0 0 0000 3",
                           if_rdy, if_gnt, if_data, dbg_state);
    end
  endtask

  task automatic test_contention();
    ex_req = 1; ex_we = 0; ex_bw = 0; ex_addr = 16'h0200;
    if_req = 1; if_addr = 16'hC002;
    @(negedge clk);
    checks++;
    if ({ex_gnt, if_gnt, MAB} !== {2'b10, 16'h0200}) begin
      failures++; $display("FAIL cont_ex_gnt: ex/if gnt=%b%b MAB=%h required 10 0200", ex_gnt, if_gnt, MAB);
    end
    @(negedge clk);
    checks++;
    if ({ex_rdy, if_rdy, ex_rdata, if_data} !== {2'b10, 16'hABCD, 16'h0000}) begin
      failures++; $display("FAIL cont_ex_rdy: rdy=%b%b rdata=%h if_data=%h required 10 ABCD 0000",
                           ex_rdy, if_rdy, ex_rdata, if_data);
    end
    ex_req = 0;
    @(negedge clk);
    checks++;
    if ({if_gnt, ex_gnt, MAB} !== {2'b10, 16'hC002}) begin
      failures++; $display("FAIL cont_if_gnt: if/ex gnt=%b%b MAB=%h required 10 C002", if_gnt, ex_gnt, MAB);
    end
    @(negedge clk);
    checks++;
    if ({if_rdy, ex_rdy, if_data, ex_rdata} !== {2'b10, 16'h1111, 16'h0000}) begin
      failures++; $display("FAIL cont_if_rdy: rdy=%b%b if_data=%h ex_rdata=%h required 10 1111 0000",
                           if_rdy, ex_rdy, if_data, ex_rdata);
    end
    if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    ex_req = 1; ex_we = 0; ex_bw = 1; ex_addr = 16'h0201;
    @(negedge clk);
    checks++;
    if ({ex_gnt, MAB, mem_re, mem_bw} !== {1'b1, 16'h0201, 2'b11}) begin
      failures++; $display("FAIL byte_hi_addr: gnt=%b MAB=%h re=%b bw=%b required 1 0201 1 1",
                           ex_gnt, MAB, mem_re, mem_bw);
    end
    @(negedge clk);
    checks++;
    if ({ex_rdy, ex_rdata} !== {1'b1, 16'h00AB}) begin
      failures++; $display("FAIL byte_hi_data: rdy=%b rdata=%h required 1 00AB", ex_rdy, ex_rdata);
    end
    ex_addr = 16'h0200;
    @(negedge clk);
    checks++;
    if ({ex_gnt, ex_rdy, MAB, mem_bw} !== {2'b10, 16'h0200, 1'b1}) begin
      failures++; $display("FAIL byte_lo_addr: gnt=%b rdy=%b MAB=%h bw=%b required 1 0 0200 1",
                           ex_gnt, ex_rdy, MAB, mem_bw);
    end
    @(negedge clk);
    checks++;
    if ({ex_rdy, ex_rdata} !== {1'b1, 16'h00CD}) begin
      failures++; $display("FAIL byte_lo_data: rdy=%b rdata=%h required 1 00CD", ex_rdy, ex_rdata);
    end
    ex_req = 0;
    @(negedge clk);
  endtask

  task automatic test_write();
    ex_req = 1; ex_we = 1; ex_bw = 0; ex_addr = 16'h0203; ex_wdata = 16'h1234;
    @(negedge clk);
    checks++;
    if ({ex_gnt, MAB, mem_re, mem_we, mem_bw, MDB_out} !== {1'b1, 16'h0202, 3'b010, 16'h1234}) begin
      failures++; $display("FAIL word_write: gnt=%b MAB=%h re/we/bw=%b%b%b MDB_out=%h required 1 0202 010 1234",
                           ex_gnt, MAB, mem_re, mem_we, mem_bw, MDB_out);
    end
    @(negedge clk);
    checks++;
    if ({ex_rdy, ex_rdata, mem_we, MDB_out} !== {1'b1, 16'h0000, 1'b0, 16'h0000}) begin
      failures++; $display("FAIL word_write_done: rdy=%b rdata=%h we=%b MDB_out=%h required 1 0000 0 0000",
                           ex_rdy, ex_rdata, mem_we, MDB_out);
    end
    ex_bw = 1; ex_wdata = 16'h125A;
    @(negedge clk);
    checks++;
    if ({ex_gnt, MAB, mem_we, mem_bw, MDB_out} !== {1'b1, 16'h0203, 2'b11, 16'h5A5A}) begin
      failures++; $display("FAIL byte_write: gnt=%b MAB=%h we=%b bw=%b MDB_out=%h required 1 0203 1 1 5A5A",
                           ex_gnt, MAB, mem_we, mem_bw, MDB_out);
    end
    @(negedge clk);
    checks++;
    if ({ex_rdy, ex_rdata} !== {1'b1, 16'h0000}) begin
      failures++; $display("FAIL byte_write_done: rdy=%b rdata=%h required 1 0000", ex_rdy, ex_rdata);
    end
    ex_req = 0; ex_we = 0; ex_bw = 0; ex_wdata = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    ex_req = 1; ex_we = 0; ex_bw = 0; ex_addr = 16'h0200;
    @(negedge clk);
    checks++;
    if (ex_gnt !== 1'b1) begin
      failures++; $display("FAIL mid_gnt: ex_gnt=%b required 1", ex_gnt);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (all_out !== 92'd0) begin
      failures++; $display("FAIL mid_reset_quiet: got %h required 0", all_out);
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if ({ex_gnt, ex_rdy, MAB, mem_re, boot_done} !== {2'b00, 16'hFFFE, 2'b10}) begin
      failures++; $display("FAIL reboot_a: gnt=%b rdy=%b MAB=%h re=%b done=%b required 0 0 FFFE 1 0",
                           ex_gnt, ex_rdy, MAB, mem_re, boot_done);
    end
    @(negedge clk);
    checks++;
    if ({pc_load, pc_init, ex_gnt, ex_rdy} !== {1'b1, 16'hC000, 2'b00}) begin
      failures++; $display("FAIL reboot_d: load=%b init=%h gnt=%b rdy=%b required 1 C000 0 0",
                           pc_load, pc_init, ex_gnt, ex_rdy);
    end
    @(negedge clk);
    checks++;
    if ({boot_done, ex_gnt, ex_rdy, dbg_state} !== {3'b100, 3'd3}) begin
      failures++; $display("FAIL reboot_idle: done=%b gnt=%b rdy=%b state=%0d required 1 0 0 3",
                           boot_done, ex_gnt, ex_rdy, dbg_state);
    end
    @(negedge clk);
    checks++;
    if ({ex_gnt, MAB} !== {1'b1, 16'h0200}) begin
      failures++; $display("FAIL pending_gnt: gnt=%b MAB=%h required 1 0200", ex_gnt, MAB);
    end
    @(negedge clk);
    checks++;
    if ({ex_rdy, ex_rdata} !== {1'b1, 16'hABCD}) begin
      failures++; $display("FAIL pending_rdy: rdy=%b rdata=%h required 1 ABCD", ex_rdy, ex_rdata);
    end
    ex_req = 0;
    @(negedge clk);
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_back_to_back();
    test_write();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
